// File: rtl/uart_baud_gen_if.sv
// Configuration and strobe bundle between the register file, the baud generator and the UART shifters.
// Widths follow the generator's channel count and divisor widths.
interface uart_baud_gen_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned INT_W  = 32,
  parameter int unsigned FRAC_W = 4
);
  logic [NUM_CH-1:0]        i_enable;
  logic [NUM_CH*INT_W-1:0]  i_sampling_delay;
  logic [NUM_CH*FRAC_W-1:0] i_frac;
  logic [NUM_CH-1:0]        i_realign;
  logic [NUM_CH-1:0]        o_tick;
  logic [NUM_CH-1:0]        o_baud;
  logic [NUM_CH-1:0]        o_clk;
  logic [NUM_CH-1:0]        o_cfg_err;

  modport master (
    output i_enable, i_sampling_delay, i_frac, i_realign,
    input  o_tick, o_baud, o_clk, o_cfg_err
  );

  modport slave (
    input  i_enable, i_sampling_delay, i_frac, i_realign,
    output o_tick, o_baud, o_clk, o_cfg_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Multi-channel fractional baud generator: oversample tick, mid-bit baud strobe and baud clock.
// Each channel is an independent IDLE/RUN down-counter with a fractional carry accumulator.
module uart_baud_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned INT_W  = 32,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OVS    = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_baud_gen_if.slave bus
);
  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_HALF     = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] PH_PRE_BAUD = PH_W'(OVS / 2 - 1);

  typedef enum logic {StIdle, StRun} st_e;

  logic [NUM_CH-1:0] tick_vec, baud_vec, clk_vec, err_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [INT_W-1:0]  d_val, d_m1, cnt_q, cnt_d;
    logic [FRAC_W-1:0] f_val, acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              en, realign, d_zero;
    logic              tick_q, tick_d, baud_q, baud_d, err_q;
    st_e               st_q, st_d;

    assign en      = bus.i_enable[c];
    assign realign = bus.i_realign[c];
    assign d_val   = bus.i_sampling_delay[c*INT_W +: INT_W];
    assign f_val   = bus.i_frac[c*FRAC_W +: FRAC_W];
    assign d_zero  = (d_val == '0);
    assign d_m1    = d_val - INT_W'(1);
    assign acc_sum = {1'b0, acc_q} + {1'b0, f_val};

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      baud_d  = 1'b0;
      unique case (st_q)
        StIdle: begin
          cnt_d   = d_m1;
          acc_d   = '0;
          phase_d = '0;
          if (en && !d_zero) st_d = StRun;
        end
        StRun: begin
          if (!en || realign || (cnt_q == '0 && d_zero)) begin
            // Restart phase; a reload that sees D == 0 parks the channel.
            cnt_d   = d_m1;
            acc_d   = '0;
            phase_d = '0;
            if (!en || d_zero) st_d = StIdle;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - INT_W'(1);
          end else begin
            tick_d  = 1'b1;
            acc_d   = acc_sum[FRAC_W-1:0];
            // D >= 1 on this path, so D-1+carry is at most D and cannot wrap.
            cnt_d   = d_m1 + INT_W'(acc_sum[FRAC_W]);
            phase_d = phase_q + PH_W'(1);
            baud_d  = (phase_q == PH_PRE_BAUD);
          end
        end
      endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        st_q    <= StIdle;
        cnt_q   <= '0;
        acc_q   <= '0;
        phase_q <= '0;
        tick_q  <= 1'b0;
        baud_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        phase_q <= phase_d;
        tick_q  <= tick_d;
        baud_q  <= baud_d;
        err_q   <= d_zero;
      end
    end

    assign tick_vec[c] = tick_q;
    assign baud_vec[c] = baud_q;
    assign clk_vec[c]  = (phase_q >= PH_HALF);
    assign err_vec[c]  = err_q;
  end

  assign bus.o_tick    = tick_vec;
  assign bus.o_baud    = baud_vec;
  assign bus.o_clk     = clk_vec;
  assign bus.o_cfg_err = err_vec;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: randomized stimulus against a closed-form tick-time model,
// plus directed checks for latency, fractional spacing, realign, divisor changes and reset.
module tb_uart_baud_gen;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned INT_W  = 32;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OVS    = 16;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  uart_baud_gen_if #(.NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

  uart_baud_gen #(.NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: the n-th tick after a restart at edge t0 lands on edge
  // t0 + n*D + floor((n-1)*F / 2^FRAC_W); phase after it is n mod OVS.
  bit                model_on = 1'b0;
  longint            edge_n   = 0;
  bit                m_active [NUM_CH];
  longint            m_t0     [NUM_CH];
  longint            m_k      [NUM_CH];
  logic [NUM_CH-1:0] exp_tick, exp_baud, exp_clk, exp_err;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_active[c] = 1'b0;
      m_t0[c]     = 0;
      m_k[c]      = 0;
    end
    exp_tick = '0;
    exp_baud = '0;
    exp_clk  = '0;
    exp_err  = '0;
  endtask

  task automatic model_edge();
    edge_n++;
    for (int c = 0; c < NUM_CH; c++) begin
      longint d;
      longint f;
      d = longint'(bus.i_sampling_delay[c*INT_W +: INT_W]);
      f = longint'(bus.i_frac[c*FRAC_W +: FRAC_W]);
      exp_err[c]  = (d == 0);
      exp_tick[c] = 1'b0;
      exp_baud[c] = 1'b0;
      if (!m_active[c]) begin
        if (bus.i_enable[c] && d != 0) begin
          m_active[c] = 1'b1;
          m_t0[c]     = edge_n;
          m_k[c]      = 0;
        end
      end else if (!bus.i_enable[c]) begin
        m_active[c] = 1'b0;
        m_k[c]      = 0;
      end else if (bus.i_realign[c]) begin
        m_t0[c] = edge_n;
        m_k[c]  = 0;
      end else if (edge_n == m_t0[c] + (m_k[c] + 1) * d + (m_k[c] * f) / (1 << FRAC_W)) begin
        exp_tick[c] = 1'b1;
        exp_baud[c] = ((m_k[c] % OVS) == OVS / 2 - 1);
        m_k[c]++;
      end
      exp_clk[c] = m_active[c] && ((m_k[c] % OVS) >= OVS / 2);
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
    if (model_on) model_edge();
  endtask

  task automatic set_cfg(input int c, input int unsigned d, input int unsigned f);
    bus.i_sampling_delay[c*INT_W +: INT_W] = INT_W'(d);
    bus.i_frac[c*FRAC_W +: FRAC_W]         = FRAC_W'(f);
  endtask

  task automatic go_idle();
    bus.i_enable  = '0;
    bus.i_realign = '0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    bus.i_enable  = '0;
    bus.i_realign = '0;
    set_cfg(0, 4, 0);
    set_cfg(1, 0, 0);
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err});
    end
    i_reset = 1'b0;
    model_reset();
    model_on = 1'b1;
    cycle();
    checks++;
    if (bus.o_cfg_err !== 2'b10) begin
      errors++;
      $display("FAIL cfg_err_d0: got %b want 10", bus.o_cfg_err);
    end
    set_cfg(1, 7, 0);
    cycle();
    checks++;
    if (bus.o_cfg_err !== 2'b00) begin
      errors++;
      $display("FAIL cfg_err_clear: got %b want 00", bus.o_cfg_err);
    end
  endtask

  task automatic test_integer_div();
    int first_tick = -1;
    int n_tick     = 0;
    int n_baud     = 0;
    set_cfg(0, 4, 0);
    set_cfg(1, 7, 0);
    bus.i_enable = 2'b11;
    for (int n = 0; n < 300; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL int_div edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b", edge_n,
                 bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
      if (bus.o_tick[0]) begin
        n_tick++;
        if (first_tick < 0) first_tick = n;
      end
      if (bus.o_baud[0]) n_baud++;
    end
    checks++;
    if (first_tick !== 4) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d want 4", first_tick);
    end
    checks++;
    if (n_tick !== 74 || n_baud !== 5) begin
      errors++;
      $display("FAIL int_div_counts: got ticks=%0d bauds=%0d want 74/5", n_tick, n_baud);
    end
    go_idle();
  endtask

  task automatic test_fractional();
    longint last = -1;
    int     nt   = 0;
    set_cfg(0, 4, 8);
    set_cfg(1, 5, $urandom_range(0, 15));
    bus.i_enable = 2'b11;
    for (int n = 0; n < 90; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL frac edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b", edge_n,
                 bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
      if (bus.o_tick[0]) begin
        nt++;
        if (last >= 0) begin
          checks++;
          if (longint'(n) - last !== ((nt % 2 == 0) ? 4 : 5)) begin
            errors++;
            $display("FAIL frac_interval tick %0d: got %0d want %0d", nt,
                     longint'(n) - last, (nt % 2 == 0) ? 4 : 5);
          end
        end
        last = n;
      end
    end
    checks++;
    if (nt !== 20) begin
      errors++;
      $display("FAIL frac_tick_count: got %0d want 20", nt);
    end
    go_idle();
  endtask

  task automatic test_realign();
    longint pred;
    int     gap       = -1;
    int     ticks     = 0;
    bit     seen_baud = 1'b0;
    set_cfg(0, 3, 0);
    set_cfg(1, $urandom_range(1, 6), $urandom_range(0, 15));
    bus.i_enable = 2'b11;
    for (int n = 0; n < 20; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL realign_warm edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                 edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
    end
    // Land the realign pulse exactly on ch0's next tick edge.
    pred = m_t0[0] + (m_k[0] + 1) * 3;
    for (int n = 0; n < 10 && edge_n + 1 < pred; n++) cycle();
    bus.i_realign[0] = 1'b1;
    cycle();
    bus.i_realign[0] = 1'b0;
    checks++;
    if (bus.o_tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL realign_suppress: got tick=%b want 0", bus.o_tick[0]);
    end
    for (int n = 1; n <= 100 && !seen_baud; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL realign_run edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                 edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
      if (bus.o_tick[0]) begin
        ticks++;
        if (gap < 0) gap = n;
      end
      if (bus.o_baud[0]) seen_baud = 1'b1;
    end
    checks++;
    if (gap !== 3) begin
      errors++;
      $display("FAIL realign_gap: got %0d want 3", gap);
    end
    checks++;
    if (ticks !== 8) begin
      errors++;
      $display("FAIL realign_baud_tick: got %0d want 8", ticks);
    end
    checks++;
    if (bus.o_clk[0] !== 1'b1) begin
      errors++;
      $display("FAIL realign_clk_high: got %b want 1", bus.o_clk[0]);
    end
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < NUM_CH; c++) bus.i_realign[c] = ($urandom_range(0, 15) == 0);
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL realign_rand edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                 edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
    end
    go_idle();
  endtask

  task automatic test_cfg_change();
    int n;
    bit seen = 1'b0;
    model_on = 1'b0;
    set_cfg(0, 5, 0);
    bus.i_enable = 2'b01;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = bus.o_tick[0];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL cfg_first_tick: got no tick want tick within 20 cycles");
    end
    cycle();
    cycle();
    set_cfg(0, 2, 0);
    n    = 2;
    seen = 1'b0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      seen = bus.o_tick[0];
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL cfg_old_period: got %0d want 5", n);
    end
    for (int j = 0; j < 2; j++) begin
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
        cycle();
        n++;
        seen = bus.o_tick[0];
      end
      checks++;
      if (n !== 2) begin
        errors++;
        $display("FAIL cfg_new_period %0d: got %0d want 2", j, n);
      end
    end
    set_cfg(0, 0, 0);
    cycle();
    checks++;
    if (bus.o_cfg_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_d0_run: got %b want 1", bus.o_cfg_err[0]);
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n += int'(bus.o_tick[0]);
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL cfg_d0_ticks: got %0d want 0", n);
    end
    checks++;
    if ({bus.o_baud[0], bus.o_clk[0]} !== 2'b00) begin
      errors++;
      $display("FAIL cfg_d0_idle_outputs: got %b want 00", {bus.o_baud[0], bus.o_clk[0]});
    end
    set_cfg(0, 3, 0);
    go_idle();
    model_reset();
    model_on = 1'b1;
  endtask

  task automatic test_channels();
    int nt;
    for (int s = 0; s < 5; s++) begin
      bus.i_enable  = '0;
      bus.i_realign = '0;
      cycle();
      if (s == 0) begin
        set_cfg(0, 2, $urandom_range(0, 15));
        set_cfg(1, 7, $urandom_range(0, 15));
      end else begin
        for (int c = 0; c < NUM_CH; c++) set_cfg(c, $urandom_range(1, 9), $urandom_range(0, 15));
      end
      bus.i_enable = 2'b11;
      for (int n = 0; n < 150; n++) begin
        cycle();
        checks++;
        if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
            {exp_tick, exp_baud, exp_clk, exp_err}) begin
          errors++;
          $display("FAIL chan seg %0d edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                   s, edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                   exp_tick, exp_baud, exp_clk, exp_err);
        end
        for (int c = 0; c < NUM_CH; c++) begin
          bus.i_realign[c] = ($urandom_range(0, 15) == 0);
          if ($urandom_range(0, 39) == 0) bus.i_enable[c] = ~bus.i_enable[c];
        end
      end
      bus.i_realign = '0;
      bus.i_enable  = 2'b10;
      nt = 0;
      for (int n = 0; n < 20; n++) begin
        cycle();
        nt += int'(bus.o_tick[0]);
        checks++;
        if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
            {exp_tick, exp_baud, exp_clk, exp_err}) begin
          errors++;
          $display("FAIL chan_off seg %0d edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                   s, edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                   exp_tick, exp_baud, exp_clk, exp_err);
        end
      end
      checks++;
      if (nt !== 0) begin
        errors++;
        $display("FAIL chan_disabled_ticks seg %0d: got %0d want 0", s, nt);
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    int first0 = -1;
    int first1 = -1;
    set_cfg(0, 5, 3);
    set_cfg(1, 1, 0);
    bus.i_enable = 2'b11;
    for (int n = 0; n < 12; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL pre_reset edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                 edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
    end
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b want 0",
               {bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err});
    end
    model_on = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
    model_on = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      checks++;
      if ({bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err} !==
          {exp_tick, exp_baud, exp_clk, exp_err}) begin
        errors++;
        $display("FAIL post_reset edge %0d: got t/b/c/e=%b/%b/%b/%b want %b/%b/%b/%b",
                 edge_n, bus.o_tick, bus.o_baud, bus.o_clk, bus.o_cfg_err,
                 exp_tick, exp_baud, exp_clk, exp_err);
      end
      if (bus.o_tick[0] && first0 < 0) first0 = n;
      if (bus.o_tick[1] && first1 < 0) first1 = n;
    end
    checks++;
    if (first0 !== 6 || first1 !== 2) begin
      errors++;
      $display("FAIL reset_restart_latency: got ch0=%0d ch1=%0d want 6/2", first0, first1);
    end
  endtask

  initial begin
    test_reset();
    test_integer_div();
    test_fractional();
    test_realign();
    test_cfg_change();
    test_channels();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
